// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: operand/result handshake bundle for cla_adder_pipe
//   master: producer/consumer side (drives in_valid, a, b, sub, out_ready)
//   slave : adder side (drives in_ready, out_valid, sum and flags)
interface cla_adder_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             sign;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero, sign
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero, sign
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined WIDTH-bit carry-lookahead add/subtract
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : slave handshake bundle; in_valid/in_ready/a/b/sub in,
//              out_valid/out_ready/sum/carry_out/overflow/zero/sign out
module cla_adder_pipe #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  cla_adder_pipe_if.slave bus
);
  localparam int NG = WIDTH / 4;
  logic [WIDTH-1:0] s1_p_q, s1_g_q, sum_q, sum_d, b_x;
  logic             s1_cin_q, s1_valid_q, out_valid_q;
  logic             carry_q, ovf_q, zero_q, sign_q;
  logic             cy, cin_msb;
  logic [3:0]       p, g, cv;
  logic             stall;
  assign b_x          = bus.b ^ {WIDTH{bus.sub}};
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~(s1_valid_q & stall);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.sign      = sign_q;
  // 4-bit lookahead inside each group; group carry-outs chain between groups
  always_comb begin
    cy      = s1_cin_q;
    cin_msb = 1'b0;
    sum_d   = '0;
    p       = '0;
    g       = '0;
    cv      = '0;
    for (int k = 0; k < NG; k++) begin
      p     = s1_p_q[4*k +: 4];
      g     = s1_g_q[4*k +: 4];
      cv[0] = cy;
      cv[1] = g[0] | p[0] & cy;
      cv[2] = g[1] | p[1] & g[0] | p[1] & p[0] & cy;
      cv[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cy;
      sum_d[4*k +: 4] = p ^ cv;
      cin_msb = cv[3];
      cy = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | (&p) & cy;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_p_q   <= bus.a ^ b_x;
          s1_g_q   <= bus.a & b_x;
          s1_cin_q <= bus.sub;
        end
      end
      if (!stall) begin
        out_valid_q <= s1_valid_q;
        // result registers only move on a real operation so they never carry junk
        if (s1_valid_q) begin
          sum_q   <= sum_d;
          carry_q <= cy;
          ovf_q   <= cin_msb ^ cy;
          zero_q  <= ~|sum_d;
          sign_q  <= sum_d[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed vectors, handshake corner cases and randomized scoreboard
module tb_cla_adder_pipe;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit rnd_on = 1'b0;
  cla_adder_pipe_if #(.WIDTH(W)) bus ();
  cla_adder_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_co, e_ov, e_z, e_sg;
  } vec_t;
  typedef struct packed {
    logic [W-1:0] sum;
    logic co, ov, z, sg;
  } res_t;
  vec_t vt[6];
  res_t q[$];
  logic [W-1:0] got[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // reference: plain integer arithmetic, signed range test for overflow
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    longint s;
    s = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
    r.sum = sub ? a - b : a + b;
    r.co  = sub ? (a >= b) : ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
    r.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.z   = (r.sum == '0);
    r.sg  = r.sum[W-1];
    return r;
  endfunction
  task automatic chk_out(input string name, input res_t e);
    chk({name, ".sum"}, 64'(bus.sum), 64'(e.sum));
    chk({name, ".co"}, 64'(bus.carry_out), 64'(e.co));
    chk({name, ".ov"}, 64'(bus.overflow), 64'(e.ov));
    chk({name, ".z"}, 64'(bus.zero), 64'(e.z));
    chk({name, ".sg"}, 64'(bus.sign), 64'(e.sg));
  endtask
  // scoreboard monitor: transfers are decided at the next posedge, so sample at negedge
  logic         prev_stall = 1'b0;
  logic [W+3:0] prev_out;
  always @(negedge clk) begin
    if (rnd_on) begin
      res_t e;
      if (prev_stall) begin
        chk("stall.valid", 64'(bus.out_valid), 64'd1);
        chk("stall.hold", 64'({bus.sum, bus.carry_out, bus.overflow, bus.zero, bus.sign}), 64'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rnd.nonempty", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_out("rnd", e);
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.sub));
      chk("rnd.inflight", 64'(q.size() <= 2), 64'd1);
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_out   = {bus.sum, bus.carry_out, bus.overflow, bus.zero, bus.sign};
    end
  end
  initial begin
    res_t e;
    vt[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{32'h12345678, 32'h0FEDCBA8, 1'b0, 32'h22222220, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk_out("rst", '{sum: '0, co: 1'b0, ov: 1'b0, z: 1'b0, sg: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    foreach (vt[i]) begin
      bus.a = vt[i].a; bus.b = vt[i].b; bus.sub = vt[i].sub; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("vec.latency", 64'(bus.out_valid), 64'd0);
      step();
      chk("vec.out_valid", 64'(bus.out_valid), 64'd1);
      chk_out($sformatf("vec%0d", i), '{vt[i].e_sum, vt[i].e_co, vt[i].e_ov, vt[i].e_z, vt[i].e_sg});
      step();
    end
    chk("vec.drained", 64'(bus.out_valid), 64'd0);
    // back-pressure: two accepts fill the pipe, third waits
    bus.out_ready = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    bus.a = 1; bus.b = 1; step();
    bus.a = 2; bus.b = 2; step();
    bus.a = 3; bus.b = 3;
    repeat (4) begin
      @(negedge clk);
      chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp.sum_hold", 64'(bus.sum), 64'd2);
      step();
    end
    bus.out_ready = 1'b1;
    got.delete();
    repeat (8) begin
      bit acc;
      @(negedge clk);
      if (bus.out_valid) got.push_back(bus.sum);
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    chk("bp.count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp.r0", 64'(got[0]), 64'd2);
      chk("bp.r1", 64'(got[1]), 64'd4);
      chk("bp.r2", 64'(got[2]), 64'd6);
    end
    // reset with two operations in flight
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.a = 32'hFFFFFFFF; bus.b = 1; step();
    bus.a = 3; bus.b = 4; step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid.busy", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
    chk_out("mid", '{sum: '0, co: 1'b0, ov: 1'b0, z: 1'b0, sg: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1; bus.a = 7; bus.b = 8; bus.sub = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("post.latency", 64'(bus.out_valid), 64'd0);
    step();
    chk("post.out_valid", 64'(bus.out_valid), 64'd1);
    chk("post.sum", 64'(bus.sum), 64'd15);
    step();
    chk("post.drained", 64'(bus.out_valid), 64'd0);
    // randomized traffic against the scoreboard
    q.delete();
    rnd_on = 1'b1;
    repeat (10000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.a   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom());
      bus.b   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom());
      bus.sub = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) step();
    rnd_on = 1'b0;
    chk("rnd.empty", 64'(q.size()), 64'd0);
    chk("rnd.idle", 64'(bus.out_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
